tree_path_emitter: RTL

TREE_PATH_EMITTER -- requirements
Module: tree_path_emitter

---
 rtl/tree_path_emitter_pkg.sv | 13 +
 rtl/user_tree_pkg.sv | 19 +
 rtl/tree_path_emitter_if.sv | 32 +++
 rtl/tree_path_lookup.sv | 23 ++
 rtl/tree_path_emitter.sv | 107 ++++++++++
 5 files changed

// File: rtl/tree_path_emitter_pkg.sv
// Shared FSM encoding and width helper for the tree path emitter.
package tree_path_emitter_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StEmit
  } state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/user_tree_pkg.sv
// Dependency tree definition: identifier widths, per-node dependency paths and node types.
package user_tree_pkg;

  localparam int unsigned NUM_MSG_HIERARCHY = 2;
  localparam int unsigned NUM_MSGS          = 2;
  localparam int unsigned IDENTIFIER_SIZE   = 5;

  typedef logic [IDENTIFIER_SIZE-1:0]       identifier;
  typedef identifier [NUM_MSG_HIERARCHY-1:0] dependency;
  typedef dependency [NUM_MSGS-1:0]          dependencies_t;
  typedef logic                              node_data;
  typedef node_data [NUM_MSGS-1:0]           node_rom_t;

  // Index [NUM_MSG_HIERARCHY-1] of each dependency is the root; 0 marks an unused level.
  localparam dependencies_t dependencies = {5'h01, 5'h00,   // node 1
                                            5'h01, 5'h04};  // node 0
  localparam node_rom_t     node_ROM     = 2'b01;

endpackage

// File: rtl/tree_path_emitter_if.sv
// Request and identifier-beat handshake bundle; master is the emitter, slave the environment.
interface tree_path_emitter_if #(
  parameter int unsigned NUM_MSG_HIERARCHY = user_tree_pkg::NUM_MSG_HIERARCHY,
  parameter int unsigned NUM_MSGS          = user_tree_pkg::NUM_MSGS,
  parameter int unsigned IDENTIFIER_SIZE   = user_tree_pkg::IDENTIFIER_SIZE
);
  import tree_path_emitter_pkg::*;

  localparam int unsigned NodeW  = clog2_min1(NUM_MSGS);
  localparam int unsigned LevelW = clog2_min1(NUM_MSG_HIERARCHY);

  logic                       req_valid;
  logic                       req_ready;
  logic [NodeW-1:0]           req_node;
  logic                       id_valid;
  logic                       id_ready;
  logic [IDENTIFIER_SIZE-1:0] id_data;
  logic [LevelW-1:0]          id_level;
  logic                       id_last;
  logic                       id_type;

  modport master (
    input  req_valid, req_node, id_ready,
    output req_ready, id_valid, id_data, id_level, id_last, id_type
  );

  modport slave (
    output req_valid, req_node, id_ready,
    input  req_ready, id_valid, id_data, id_level, id_last, id_type
  );

endinterface

// File: rtl/tree_path_lookup.sv
// Combinational read of the dependency table and node types, with node range check.
module tree_path_lookup #(
  parameter int unsigned NUM_MSGS = user_tree_pkg::NUM_MSGS,
  parameter int unsigned NodeW    = 1
) (
  input  logic [NodeW-1:0]         i_node,
  output user_tree_pkg::dependency o_dep,
  output user_tree_pkg::node_data  o_type,
  output logic                     o_in_range
);

  always_comb begin
    // A narrowed NUM_MSGS override must also reject nodes the table still holds.
    o_in_range = (32'(i_node) < NUM_MSGS) && (32'(i_node) < user_tree_pkg::NUM_MSGS);
    o_dep      = '0;
    o_type     = '0;
    if (o_in_range) begin
      o_dep  = user_tree_pkg::dependencies[i_node];
      o_type = user_tree_pkg::node_ROM[i_node];
    end
  end

endmodule

// File: rtl/tree_path_emitter.sv
// Emits a node's dependency path root-first as identifier beats, stopping at the first unused level.
module tree_path_emitter
  import tree_path_emitter_pkg::*;
#(
  parameter int unsigned NUM_MSG_HIERARCHY = user_tree_pkg::NUM_MSG_HIERARCHY,
  parameter int unsigned NUM_MSGS          = user_tree_pkg::NUM_MSGS,
  parameter int unsigned IDENTIFIER_SIZE   = user_tree_pkg::IDENTIFIER_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  tree_path_emitter_if.master bus,
  output logic                err,
  output logic [15:0]         paths_sent
);

  localparam int unsigned       NodeW     = clog2_min1(NUM_MSGS);
  localparam int unsigned       LevelW    = clog2_min1(NUM_MSG_HIERARCHY);
  localparam logic [LevelW-1:0] RootLevel = LevelW'(NUM_MSG_HIERARCHY - 1);

  state_e                     r_state, w_state_next;
  user_tree_pkg::dependency   r_dep, w_lut_dep;
  user_tree_pkg::node_data    r_type, w_lut_type;
  logic                       w_lut_in_range;
  logic [LevelW-1:0]          r_level, w_level_next;
  logic                       r_err;
  logic [15:0]                r_paths_sent, w_paths_next;
  logic                       w_accept, w_load, w_reject;
  logic                       w_valid, w_beat_done, w_last;
  logic [IDENTIFIER_SIZE-1:0] w_cur_id, w_lower_id;

  tree_path_lookup #(
    .NUM_MSGS (NUM_MSGS),
    .NodeW    (NodeW)
  ) u_lookup (
    .i_node     (bus.req_node),
    .o_dep      (w_lut_dep),
    .o_type     (w_lut_type),
    .o_in_range (w_lut_in_range)
  );

  assign w_accept = (r_state == StIdle) && bus.req_valid;
  assign w_load   = w_accept && w_lut_in_range && (w_lut_dep[RootLevel] != '0);
  assign w_reject = w_accept && !w_load;

  assign w_valid     = (r_state == StEmit);
  assign w_beat_done = w_valid && bus.id_ready;
  assign w_cur_id    = r_dep[r_level];
  // Guarded so level 0 never wraps to an out-of-range index.
  assign w_lower_id  = (r_level == '0) ? '0 : r_dep[r_level - LevelW'(1)];
  assign w_last      = (r_level == '0) || (w_lower_id == '0);

  always_comb begin
    w_state_next = r_state;
    w_level_next = r_level;
    w_paths_next = r_paths_sent;
    unique case (r_state)
      StIdle: begin
        if (w_load) begin
          w_state_next = StEmit;
          w_level_next = RootLevel;
        end
      end
      StEmit: begin
        if (w_beat_done) begin
          if (w_last) begin
            w_state_next = StIdle;
            if (r_paths_sent != 16'hFFFF) begin
              w_paths_next = r_paths_sent + 16'd1;
            end
          end else begin
            w_level_next = r_level - LevelW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_level      <= '0;
      r_dep        <= '0;
      r_type       <= '0;
      r_err        <= 1'b0;
      r_paths_sent <= '0;
    end else begin
      r_state      <= w_state_next;
      r_level      <= w_level_next;
      r_err        <= w_reject;
      r_paths_sent <= w_paths_next;
      if (w_load) begin
        r_dep  <= w_lut_dep;
        r_type <= w_lut_type;
      end
    end
  end

  assign bus.req_ready = (r_state == StIdle);
  assign bus.id_valid  = w_valid;
  assign bus.id_data   = w_valid ? w_cur_id : '0;
  assign bus.id_level  = w_valid ? r_level : '0;
  assign bus.id_last   = w_valid && w_last;
  assign bus.id_type   = w_valid && r_type;
  assign err           = r_err;
  assign paths_sent    = r_paths_sent;

endmodule
